// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } rx_ctrl_state_t;

    localparam int ERR_W       = 2;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_FRAMING = 0;

    function automatic int entry_width(input int data_width);
        return data_width + ERR_W;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered read port; the head entry appears one clock after its write.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_C);
    assign empty = (count == '0);

    always_comb begin
        rd_en      = pop && !empty;
        wr_en      = push && (!full || rd_en);
        rd_ptr_nxt = rd_en ? rd_ptr + 1'b1 : rd_ptr;
        count_nxt  = count + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // The output register preloads the next head; a write landing on that slot is bypassed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt == '0) begin
                dout <= '0;
            end else if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
                dout <= din;
            end else begin
                dout <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Host-side controller for the UART receiver: parity config, frame capture into a FIFO,
// saturating error/overrun counters and a level interrupt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int IRQ_THRESH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_wr,
    input  logic                              cfg_enable,
    input  logic                              cfg_parity_en,
    input  logic                              cfg_odd_parity,
    input  logic                              cfg_drop_bad,
    input  logic                              rx_done,
    input  logic [DATA_WIDTH-1:0]             rx_data,
    input  logic                              rx_framing_err,
    input  logic                              rx_parity_err,
    output logic                              rx_parity_en,
    output logic                              rx_odd_even,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [1:0]                        m_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [CNT_WIDTH-1:0]              framing_cnt,
    output logic [CNT_WIDTH-1:0]              parity_cnt,
    output logic [CNT_WIDTH-1:0]              overrun_cnt,
    output logic                              irq,
    input  logic                              irq_clr,
    input  logic                              cnt_clr
);

    localparam int EW = entry_width(DATA_WIDTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [FCW-1:0] THRESH_C = FCW'(IRQ_THRESH);

    rx_ctrl_state_t state, state_nxt;

    logic             cfg_enable_q;
    logic             cfg_parity_q;
    logic             cfg_odd_q;
    logic             cfg_drop_q;
    logic             rx_done_q;
    logic             err_flag;
    logic             ovr_flag;
    logic             irq_q;

    logic             capture;
    logic             frame_err;
    logic             push;
    logic             pop;
    logic             overrun;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ERR_W-1:0] rx_err;
    logic [EW-1:0]    fifo_din;
    logic [EW-1:0]    fifo_dout;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 inc,
        input logic                 clr
    );
        if (clr) begin
            return CNT_WIDTH'(inc);
        end
        if (inc && (cur != '1)) begin
            return cur + 1'b1;
        end
        return cur;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (cfg_enable_q) state_nxt = SYNC;
            SYNC:    if (!rx_done)     state_nxt = RUN;
            RUN:     if (!cfg_enable_q) state_nxt = OFF;
            default: state_nxt = OFF;
        endcase
    end

    always_comb begin
        rx_err              = '0;
        rx_err[ERR_PARITY]  = rx_parity_err;
        rx_err[ERR_FRAMING] = rx_framing_err;
        fifo_din            = {rx_err, rx_data};
        capture             = (state == RUN) && rx_done && !rx_done_q;
        frame_err           = rx_framing_err || rx_parity_err;
        push                = capture && !(frame_err && cfg_drop_q);
        pop                 = m_valid && m_ready;
        overrun             = push && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OFF;
            cfg_enable_q <= 1'b0;
            cfg_parity_q <= 1'b0;
            cfg_odd_q    <= 1'b0;
            cfg_drop_q   <= 1'b0;
            rx_done_q    <= 1'b0;
            err_flag     <= 1'b0;
            ovr_flag     <= 1'b0;
            irq_q        <= 1'b0;
            framing_cnt  <= '0;
            parity_cnt   <= '0;
            overrun_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            rx_done_q <= rx_done;
            if (cfg_wr) begin
                cfg_enable_q <= cfg_enable;
                cfg_parity_q <= cfg_parity_en;
                cfg_odd_q    <= cfg_odd_parity;
                cfg_drop_q   <= cfg_drop_bad;
            end
            // A new event takes priority over the clear so it is never lost.
            if (capture && frame_err) begin
                err_flag <= 1'b1;
            end else if (irq_clr) begin
                err_flag <= 1'b0;
            end
            if (overrun) begin
                ovr_flag <= 1'b1;
            end else if (irq_clr) begin
                ovr_flag <= 1'b0;
            end
            irq_q       <= (fifo_count >= THRESH_C) | err_flag | ovr_flag;
            framing_cnt <= cnt_next(framing_cnt, capture && rx_framing_err, cnt_clr);
            parity_cnt  <= cnt_next(parity_cnt, capture && rx_parity_err, cnt_clr);
            overrun_cnt <= cnt_next(overrun_cnt, overrun, cnt_clr);
        end
    end

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_valid      = !fifo_empty;
    assign m_data       = fifo_dout[DATA_WIDTH-1:0];
    assign m_err        = fifo_dout[EW-1:DATA_WIDTH];
    assign irq          = irq_q;
    assign rx_parity_en = cfg_parity_q;
    assign rx_odd_even  = cfg_odd_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model checked every cycle, plus literal spot checks.
module tb_uart_rx_ctrl;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int CNTW   = 8;
    localparam int THRESH = 4;
    localparam int CMAX   = (1 << CNTW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_wr, cfg_enable, cfg_parity_en, cfg_odd_parity, cfg_drop_bad;
    logic           rx_done, rx_framing_err, rx_parity_err;
    logic [DW-1:0]  rx_data;
    logic           rx_parity_en, rx_odd_even;
    logic           m_valid, m_ready;
    logic [DW-1:0]  m_data;
    logic [1:0]     m_err;
    logic [3:0]     fifo_count;
    logic [CNTW-1:0] framing_cnt, parity_cnt, overrun_cnt;
    logic           irq, irq_clr, cnt_clr;

    uart_rx_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CNTW),
        .IRQ_THRESH (THRESH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_wr         (cfg_wr),
        .cfg_enable     (cfg_enable),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_odd_parity (cfg_odd_parity),
        .cfg_drop_bad   (cfg_drop_bad),
        .rx_done        (rx_done),
        .rx_data        (rx_data),
        .rx_framing_err (rx_framing_err),
        .rx_parity_err  (rx_parity_err),
        .rx_parity_en   (rx_parity_en),
        .rx_odd_even    (rx_odd_even),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_err          (m_err),
        .fifo_count     (fifo_count),
        .framing_cnt    (framing_cnt),
        .parity_cnt     (parity_cnt),
        .overrun_cnt    (overrun_cnt),
        .irq            (irq),
        .irq_clr        (irq_clr),
        .cnt_clr        (cnt_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = disabled, 1 = waiting for done low, 2 = capturing.
    int  q_data[$];
    int  q_err[$];
    int  mf, mp, mo;
    bit  m_errf, m_ovrf, m_irq, m_pen, m_odd, m_en, m_drop, m_prev;
    int  phase;
    bit  started = 0;

    function automatic int sat_inc(input int cur, input bit inc, input bit clr);
        if (clr) return inc ? 1 : 0;
        if (inc && cur < CMAX) return cur + 1;
        return cur;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_data.delete();
            q_err.delete();
            mf = 0; mp = 0; mo = 0;
            m_errf = 0; m_ovrf = 0; m_irq = 0;
            m_pen = 0; m_odd = 0; m_en = 0; m_drop = 0; m_prev = 0;
            phase = 0;
            started = 1;
        end else if (started) begin
            bit irq_n, pop, cap, bad, push, ovr;
            irq_n = (q_data.size() >= THRESH) || m_errf || m_ovrf;
            pop   = (q_data.size() > 0) && m_ready;
            cap   = (phase == 2) && rx_done && !m_prev;
            bad   = cap && (rx_framing_err || rx_parity_err);
            push  = cap && !(bad && m_drop);
            ovr   = push && (q_data.size() == DEPTH) && !pop;
            mf = sat_inc(mf, cap && rx_framing_err, cnt_clr);
            mp = sat_inc(mp, cap && rx_parity_err, cnt_clr);
            mo = sat_inc(mo, ovr, cnt_clr);
            if (bad) m_errf = 1; else if (irq_clr) m_errf = 0;
            if (ovr) m_ovrf = 1; else if (irq_clr) m_ovrf = 0;
            if (pop) begin
                void'(q_data.pop_front());
                void'(q_err.pop_front());
            end
            if (push && !ovr) begin
                q_data.push_back(int'(rx_data));
                q_err.push_back((rx_parity_err ? 2 : 0) + (rx_framing_err ? 1 : 0));
            end
            case (phase)
                0: if (m_en) phase = 1;
                1: if (!rx_done) phase = 2;
                default: if (!m_en) phase = 0;
            endcase
            m_prev = rx_done;
            if (cfg_wr) begin
                m_en = cfg_enable; m_pen = cfg_parity_en;
                m_odd = cfg_odd_parity; m_drop = cfg_drop_bad;
            end
            m_irq = irq_n;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", m_valid, q_data.size() > 0);
            if (q_data.size() > 0) begin
                chk("m_data", m_data, q_data[0]);
                chk("m_err", m_err, q_err[0]);
            end
            chk("fifo_count", fifo_count, q_data.size());
            chk("framing_cnt", framing_cnt, mf);
            chk("parity_cnt", parity_cnt, mp);
            chk("overrun_cnt", overrun_cnt, mo);
            chk("irq", irq, m_irq);
            chk("rx_parity_en", rx_parity_en, m_pen);
            chk("rx_odd_even", rx_odd_even, m_odd);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input bit en, input bit pe, input bit odd, input bit drop);
        cfg_wr = 1; cfg_enable = en; cfg_parity_en = pe;
        cfg_odd_parity = odd; cfg_drop_bad = drop;
        tick(1);
        cfg_wr = 0;
    endtask

    task automatic frame(input int data, input bit fe, input bit pe, input int hold, input int gap);
        rx_data = DW'(data); rx_framing_err = fe; rx_parity_err = pe;
        rx_done = 1;
        tick(hold);
        rx_done = 0;
        tick(gap);
    endtask

    task automatic drain();
        m_ready = 1;
        tick(DEPTH + 2);
        m_ready = 0;
    endtask

    task automatic spot(input string name, input longint act, input longint exp);
        @(negedge clk);
        chk(name, act, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; cfg_wr = 0; cfg_enable = 0; cfg_parity_en = 0; cfg_odd_parity = 0;
        cfg_drop_bad = 0; rx_done = 0; rx_data = '0; rx_framing_err = 0; rx_parity_err = 0;
        m_ready = 0; irq_clr = 0; cnt_clr = 0;
        tick(2);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_irq", irq, 0);
        rst = 0;
        tick(1);

        // 1: clean frame, then same frame with a long done pulse
        cfg(1, 1, 0, 0);
        tick(2);
        frame('hA5, 0, 0, 1, 2);
        chk("t1_count", fifo_count, 1);
        chk("t1_data", m_data, 'hA5);
        chk("t1_err", m_err, 0);
        frame('hA5, 0, 0, 16, 2);
        chk("t1_hold_count", fifo_count, 2);
        drain();

        // 2: enable while done is already high
        cfg(0, 1, 0, 0);
        tick(2);
        rx_done = 1; rx_data = 'h5A;
        cfg(1, 1, 0, 0);
        tick(5);
        spot("t2_stale", fifo_count, 0);
        rx_done = 0;
        tick(3);
        frame('h11, 0, 0, 1, 2);
        spot("t2_new", m_data, 'h11);
        drain();

        // 3: overflow, ordered drain, sticky irq
        for (int i = 0; i < 9; i++) frame('h40 + i, 0, 0, 1, 1);
        tick(1);
        spot("t3_count", fifo_count, 8);
        spot("t3_ovr", overrun_cnt, 1);
        spot("t3_irq", irq, 1);
        m_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_order", m_data, 'h40 + i);
            @(posedge clk);
            #1;
        end
        m_ready = 0;
        tick(2);
        spot("t3_irq_sticky", irq, 1);
        irq_clr = 1; tick(1); irq_clr = 0; tick(1);
        spot("t3_irq_cleared", irq, 0);

        // 4: parity error kept, then dropped
        frame('h3C, 0, 1, 1, 2);
        spot("t4_err", m_err, 2);
        spot("t4_pcnt", parity_cnt, 1);
        drain();
        cfg(1, 1, 0, 1);
        frame('h3C, 0, 1, 1, 2);
        spot("t4_drop_count", fifo_count, 0);
        spot("t4_pcnt2", parity_cnt, 2);
        spot("t4_irq", irq, 1);
        irq_clr = 1; tick(1); irq_clr = 0;

        // 5: push+pop while full, then saturation and clear interactions
        cfg(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) frame('h80 + i, 0, 0, 1, 1);
        rx_data = 'h88; rx_done = 1; m_ready = 1;
        tick(1);
        rx_done = 0; m_ready = 0;
        tick(2);
        spot("t5_count", fifo_count, 8);
        spot("t5_head", m_data, 'h81);
        drain();
        cfg(1, 1, 0, 1);
        cnt_clr = 1; tick(1); cnt_clr = 0;
        for (int i = 0; i < 260; i++) frame(i, 1, 1, 1, 1);
        tick(1);
        spot("t5_fsat", framing_cnt, 'hFF);
        spot("t5_psat", parity_cnt, 'hFF);
        rx_framing_err = 1; rx_parity_err = 0; rx_done = 1; cnt_clr = 1; irq_clr = 1;
        tick(1);
        rx_done = 0; cnt_clr = 0; irq_clr = 0;
        tick(2);
        spot("t5_clr_inc", framing_cnt, 1);
        spot("t5_clr_parity", parity_cnt, 0);
        spot("t5_err_wins", irq, 1);
        irq_clr = 1; tick(1); irq_clr = 0;

        // randomized traffic
        cfg(1, 1, 0, 0);
        for (int i = 0; i < 800; i++) begin
            rx_done        = ($urandom_range(0, 2) == 0);
            rx_data        = DW'($urandom);
            rx_framing_err = ($urandom_range(0, 4) == 0);
            rx_parity_err  = ($urandom_range(0, 4) == 0);
            m_ready        = ($urandom_range(0, 2) != 0);
            irq_clr        = ($urandom_range(0, 15) == 0);
            cnt_clr        = ($urandom_range(0, 63) == 0);
            cfg_wr         = ($urandom_range(0, 39) == 0);
            cfg_enable     = ($urandom_range(0, 3) != 0);
            cfg_parity_en  = 1'($urandom);
            cfg_odd_parity = 1'($urandom);
            cfg_drop_bad   = 1'($urandom);
            tick(1);
        end
        cfg_wr = 0; irq_clr = 0; cnt_clr = 0; m_ready = 0; rx_done = 0;
        rx_framing_err = 0; rx_parity_err = 0;

        // 6: reset mid-burst, then parity configuration
        cfg(1, 1, 0, 0);
        tick(2);
        for (int i = 0; i < 5; i++) frame('h60 + i, 1, 0, 1, 1);
        rx_done = 1;
        rst = 1; tick(1); rst = 0; rx_done = 0;
        @(negedge clk);
        chk("t6_valid", m_valid, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_fcnt", framing_cnt, 0);
        chk("t6_irq", irq, 0);
        chk("t6_pen", rx_parity_en, 0);
        @(posedge clk);
        #1;
        cfg(0, 1, 1, 0);
        @(negedge clk);
        chk("t6_odd_pen", rx_parity_en, 1);
        chk("t6_odd_oe", rx_odd_even, 1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
